vga_capture_dma: RTL
====================

# vga_capture_dma

Video capture engine: the write-side counterpart of the VGA scan-out peripheral. It receives a pixel stream with sync strobes, decimates and packs pixels into the same 4:4:4 VRAM word layout the scan-out path reads, and writes them through a `boa_mem_bus` initiator port into the dual-port video RAM. A captured frame can therefore be displayed without conversion. Sits between an external video receiver front-end and the VRAM's memory-side port.

## Interface
Parameters:
- `fifo_depth`, 8: write FIFO entries (power of two, ≥2).
- `x_len`, 10: horizontal pixel counter width.
- `y_len`, 10: vertical line counter width.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, **asynchronous, active-low**.
- `mem_bus` `boa_mem_bus.CPU` (17-bit address): VRAM write initiator.
- `in_vsync` in 1: frame start strobe, active-high.
- `in_hsync` in 1: line start strobe, active-high.
- `in_valid` in 1: `in_rgb` holds an active pixel this cycle.
- `in_rgb` in 12: `{r[3:0], g[3:0], b[3:0]}`.
- `cfg_shr` in 4: decimation shift, same meaning as scan-out `shr_width`.
- `cfg_continuous` in 1: 1 = capture every frame, 0 = one-shot.
- `arm` in 1: pulse; requests capture starting at the next vsync.
- `abort` in 1: pulse; stops capture, drains FIFO, goes idle.
- `ovf_clr` in 1: clears `overflow`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse when the final word of a frame has been accepted.
- `overflow` out 1: sticky; a packed word was dropped because the FIFO was full.

## Operation
- Sync handling: edge-detect `in_vsync`/`in_hsync` (previous-level register).
  - vsync rise: x=0, y=0.
  - hsync rise: x=0, and y increments only if the previous line saw ≥1 valid pixel.
  - Each `in_valid` increments x after use.
- Pixel keep rule: `(x & m)==0 && (y & m)==0`, where `m = (1<<cfg_shr)-1`.
  - `p = x>>cfg_shr`, `l = y>>cfg_shr`.
  - Drop the pixel if `p ≥ 256` or `l ≥ 256`.
- Packing:
  - Even `p`: store `{4'h0, rgb}` as the low half; pending=1.
  - Odd `p`: push word `{4'h0, rgb, lo_half}` with `we=4'b1111`.
  - Pending low half at hsync/vsync rise or capture end: push with `we=4'b0011`, high half zero.
- Address: `addr[16:9]=l[7:0]`, `addr[8:2]=p[7:1]`, `addr[1:0]=0`. Matches scan-out VRAM mapping.
- Capture FSM:
  - IDLE: `arm` → ARMED.
  - ARMED: vsync rise → CAPTURE.
  - CAPTURE:
    - vsync rise with `cfg_continuous=1`: flush pending, stay in CAPTURE; `done` pulses when that frame's last word is accepted.
    - vsync rise with `cfg_continuous=0`: flush pending → DRAIN.
    - `abort` (from ARMED or CAPTURE): pending half is discarded → DRAIN.
  - DRAIN: FIFO empty and no bus write outstanding → IDLE, pulse `done` (unless entered by abort).
- Pixels are ignored outside CAPTURE.
- Write port: `re=0`. While the FIFO is non-empty, present the head entry (`we`, `addr`, `wdata`) and hold it stable until `ready`; pop on `ready`.
- Overflow: a push into a full FIFO is dropped and sets `overflow`. Set wins over a simultaneous `ovf_clr`.
- `cfg_shr` is sampled at vsync rise into CAPTURE and is constant for the frame.

## Timing
- Reset values: `busy=0`, `done=0`, `overflow=0`, `mem_bus.we=0`, `re=0`, `addr=0`, `wdata=0`; FSM IDLE; FIFO empty; counters 0.
- Pixel → FIFO push: 1 cycle after the `in_valid` of the completing pixel.
- FIFO empty → bus `we` asserted: the cycle after the push. Throughput is one word per cycle when `ready` stays high.
- Simultaneous push and pop on a full FIFO: the push is accepted.
- `arm` while busy: ignored.
- `abort` and `arm` in the same cycle: `abort` wins.
- Reset mid-write: the bus is released immediately; no partial-word guarantees.

## Configuration
- `VGA_CAPTURE_FRAMECNT_EN` defined:
  - Adds output `frame_count[15:0]`: increments on each `done`, wraps at 16'hFFFF→0, reset 0, cleared on `arm` in IDLE.
- Undefined: the port is absent; no counter logic.

## Structure
- Shared package `vga_capture_pkg`:
  - FIFO entry typedef `{addr[16:0], wdata[31:0], we[3:0]}`.
  - FSM state enum (IDLE, ARMED, CAPTURE, DRAIN).
  - Constants: `line_words=128`, `max_lines=256`.
- One sub-module `vga_capture_fifo`: synchronous FIFO with full/empty and registered head output. Packing, counters and FSM stay in the top module.

## Test plan
- `cfg_shr=0`, one-shot, 4×2 frame with pixels 0x111,0x222,0x333,0x444 / 0x555…: words 0x0222_0111 @0x00000, 0x0444_0333 @0x00004, line 1 @0x00200; `done` once; `busy` falls.
- 3-pixel line: third pixel written as 0x0000_0333 with `we=4'b0011` at 0x00004.
- `cfg_shr=1`, 8×4 frame: only even x/y kept; line y=2 maps to 0x00200; 2 words per kept line.
- `ready` held low for 20 cycles with fifo_depth=8 and a 32-pixel line: 8 words buffered, rest dropped; `overflow=1`; `ovf_clr` clears it.
- Continuous mode, 3 frames: 3 `done` pulses; `frame_count=3` with the macro defined.
- `abort` mid-line: pending half discarded, FIFO drains, `busy`=0, no `done`.

Source files
------------

// File: rtl/vga_capture_pkg.sv
// -----------------------------------------------------------------------------
// vga_capture_pkg
// Shared types and constants for the VGA capture engine:
//   fifo_entry_t  - one VRAM write (address, data, byte enables)
//   cap_state_e   - capture FSM states
//   vram_addr()   - line/pixel-pair to VRAM byte address, same mapping the
//                   scan-out side reads
// -----------------------------------------------------------------------------
package vga_capture_pkg;

    localparam int line_words = 128;   // 32-bit words per VRAM line (2 pixels each)
    localparam int max_lines  = 256;   // lines held in VRAM
    localparam int PIX_BITS   = $clog2(line_words * 2);
    localparam int LINE_BITS  = $clog2(max_lines);

    typedef struct packed {
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } cap_state_e;

    // Line in [16:9], pixel pair in [8:2], word aligned.
    function automatic logic [16:0] vram_addr(input logic [7:0] l, input logic [7:0] p);
        return {l, p[7:1], 2'b00};
    endfunction

endpackage

// File: rtl/vga_capture_dma_if.sv
// -----------------------------------------------------------------------------
// boa_mem_bus
// Simple memory bus between an initiator (CPU modport) and the VRAM port
// (MEM modport). A transfer completes in the cycle where the initiator drives
// re or a non-zero we and the target drives ready.
//   re     : read request (unused by the capture engine, held at 0)
//   we     : per-byte write enables
//   addr   : 17-bit byte address
//   wdata  : write data
//   rdata  : read data
//   ready  : target accepts the current request
// -----------------------------------------------------------------------------
interface boa_mem_bus;
    logic        re;
    logic [3:0]  we;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport CPU (output re, output we, output addr, output wdata,
                 input  rdata, input ready);
    modport MEM (input  re, input we, input addr, input wdata,
                 output rdata, output ready);
endinterface

// File: rtl/vga_capture_fifo.sv
// -----------------------------------------------------------------------------
// vga_capture_fifo
// Synchronous write FIFO of fifo_entry_t. The head entry comes straight from
// the storage registers and reads as all-zero while empty, so it can drive
// the bus directly.
//   clk, rst  : clock, asynchronous active-low reset
//   push_i    : write din_i (dropped when full unless popping the same cycle)
//   din_i     : entry to write
//   pop_i     : remove head entry (ignored when empty)
//   head_o    : current head entry, zero when empty
//   full_o    : FIFO full
//   empty_o   : FIFO empty
//   count_o   : number of stored entries
//   drop_o    : this cycle's push is being discarded
// -----------------------------------------------------------------------------
module vga_capture_fifo
    import vga_capture_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  fifo_entry_t                din_i,
    input  logic                       pop_i,
    output fifo_entry_t                head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t    mem_q [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [AW:0]    cnt_q;
    logic           wr_en;
    logic           rd_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign rd_en   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still lands (it overwrites the head exactly as the head leaves).
    assign wr_en   = push_i && (!full_o || rd_en);
    assign drop_o  = push_i && !wr_en;
    assign count_o = cnt_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/vga_capture_dma.sv
// -----------------------------------------------------------------------------
// vga_capture_dma
// Captures a synced pixel stream, decimates by 2^cfg_shr in x and y, packs
// pixel pairs into 4:4:4 VRAM words and writes them out over boa_mem_bus.
//   clk, rst          : clock, asynchronous active-low reset
//   mem_bus (CPU)     : VRAM write initiator (re always 0)
//   in_vsync/in_hsync : frame / line start strobes (rising edge used)
//   in_valid, in_rgb  : active pixel {r,g,b} 4 bits each
//   cfg_shr           : decimation shift, latched at each frame start
//   cfg_continuous    : 1 = keep capturing frames, 0 = one frame
//   arm / abort       : start at next vsync / stop and drain
//   ovf_clr           : clear sticky overflow
//   busy, done        : not idle / frame fully written (one-cycle pulse)
//   overflow          : sticky, a word was dropped on a full FIFO
// Optional: VGA_CAPTURE_FRAMECNT_EN adds frame_count[15:0] counting done
// pulses (cleared by arm from idle).
// -----------------------------------------------------------------------------
module vga_capture_dma
    import vga_capture_pkg::*;
#(
    parameter int fifo_depth = 8,
    parameter int x_len      = 10,
    parameter int y_len      = 10
) (
    input  logic          clk,
    input  logic          rst,
    boa_mem_bus.CPU       mem_bus,
    input  logic          in_vsync,
    input  logic          in_hsync,
    input  logic          in_valid,
    input  logic [11:0]   in_rgb,
    input  logic [3:0]    cfg_shr,
    input  logic          cfg_continuous,
    input  logic          arm,
    input  logic          abort,
    input  logic          ovf_clr,
    output logic          busy,
    output logic          done,
    output logic          overflow
`ifdef VGA_CAPTURE_FRAMECNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);
    localparam int CW = $clog2(fifo_depth);

    cap_state_e         state_q;
    logic               vs_prev_q, hs_prev_q, line_valid_q;
    logic [x_len-1:0]   x_q;
    logic [y_len-1:0]   y_q;
    logic [3:0]         shr_q;
    logic               pend_q, pend_d;
    logic [11:0]        lo_q, lo_d;
    logic [16:0]        pend_addr_q, pend_addr_d;
    logic               busy_q, done_q, ovf_q, aborted_q, cd_wait_q;
    logic [CW:0]        cd_cnt_q;

    logic               vs_rise, hs_rise, capturing, flush, keep;
    logic [x_len-1:0]   x_cur, x_mask, p;
    logic [y_len-1:0]   y_cur, y_mask, l;
    logic               push, pop, drop, fifo_full, fifo_empty;
    fifo_entry_t        push_entry, head;
    logic [CW:0]        fifo_cnt, cnt_after;

    assign vs_rise   = in_vsync && !vs_prev_q;
    assign hs_rise   = in_hsync && !hs_prev_q;
    // A pixel arriving with a sync edge belongs to the new line/frame.
    assign x_cur     = (vs_rise || hs_rise) ? '0 : x_q;
    assign y_cur     = vs_rise ? '0 : (hs_rise ? y_q + y_len'(line_valid_q) : y_q);
    assign x_mask    = x_len'((32'd1 << shr_q) - 32'd1);
    assign y_mask    = y_len'((32'd1 << shr_q) - 32'd1);
    assign p         = x_cur >> shr_q;
    assign l         = y_cur >> shr_q;
    assign capturing = (state_q == CAPTURE) && !abort;
    assign flush     = capturing && pend_q && (vs_rise || hs_rise);
    assign keep      = capturing && !vs_rise && in_valid
                       && ((x_cur & x_mask) == '0) && ((y_cur & y_mask) == '0)
                       && ((p >> PIX_BITS) == '0) && ((l >> LINE_BITS) == '0);

    always_comb begin
        push        = 1'b0;
        push_entry  = '0;
        pend_d      = pend_q;
        lo_d        = lo_q;
        pend_addr_d = pend_addr_q;
        if (flush) begin
            push             = 1'b1;
            push_entry.addr  = pend_addr_q;
            push_entry.wdata = {20'h0, lo_q};
            push_entry.we    = 4'b0011;
            pend_d           = 1'b0;
        end
        if (keep) begin
            if (!p[0]) begin
                pend_d      = 1'b1;
                lo_d        = in_rgb;
                pend_addr_d = vram_addr(8'(l), 8'(p));
            end else begin
                push             = 1'b1;
                push_entry.addr  = vram_addr(8'(l), 8'(p));
                push_entry.wdata = {4'h0, in_rgb, 4'h0, (pend_q ? lo_q : 12'h0)};
                push_entry.we    = 4'b1111;
                pend_d           = 1'b0;
            end
        end
        // Half-filled word is thrown away on abort or outside capture.
        if (!capturing) begin
            pend_d = 1'b0;
        end
    end

    vga_capture_fifo #(.DEPTH(fifo_depth)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt),
        .drop_o  (drop)
    );

    assign pop           = mem_bus.ready && !fifo_empty;
    assign cnt_after     = fifo_cnt + (CW+1)'(push && !drop) - (CW+1)'(pop);
    assign mem_bus.re    = 1'b0;
    assign mem_bus.we    = head.we;
    assign mem_bus.addr  = head.addr;
    assign mem_bus.wdata = head.wdata;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_prev_q    <= 1'b0;
            hs_prev_q    <= 1'b0;
            line_valid_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            pend_q       <= 1'b0;
            lo_q         <= '0;
            pend_addr_q  <= '0;
            ovf_q        <= 1'b0;
        end else begin
            vs_prev_q    <= in_vsync;
            hs_prev_q    <= in_hsync;
            line_valid_q <= ((vs_rise || hs_rise) ? 1'b0 : line_valid_q) | in_valid;
            x_q          <= x_cur + x_len'(in_valid);
            y_q          <= y_cur;
            pend_q       <= pend_d;
            lo_q         <= lo_d;
            pend_addr_q  <= pend_addr_d;
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // Capture FSM. In continuous mode cd_cnt_q counts the words of the
    // finished frame still queued; done fires when the last one is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            shr_q     <= '0;
            cd_wait_q <= 1'b0;
            cd_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (cd_wait_q && pop) begin
                cd_cnt_q <= cd_cnt_q - 1'b1;
                if (cd_cnt_q == (CW+1)'(1)) begin
                    cd_wait_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (arm && !abort) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (abort) begin
                        state_q   <= DRAIN;
                        aborted_q <= 1'b1;
                    end else if (vs_rise) begin
                        state_q <= CAPTURE;
                        shr_q   <= cfg_shr;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        state_q   <= DRAIN;
                        aborted_q <= 1'b1;
                        cd_wait_q <= 1'b0;
                    end else if (vs_rise) begin
                        if (cfg_continuous) begin
                            shr_q <= cfg_shr;
                            if (cnt_after == '0) begin
                                done_q    <= 1'b1;
                                cd_wait_q <= 1'b0;
                            end else begin
                                cd_wait_q <= 1'b1;
                                cd_cnt_q  <= cnt_after;
                            end
                        end else begin
                            state_q   <= DRAIN;
                            aborted_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!aborted_q) done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef VGA_CAPTURE_FRAMECNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if ((state_q == IDLE) && arm && !abort) begin
            frame_cnt_q <= '0;
        end else if (done_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`endif

endmodule
